// File: rtl/adc_decimator_if.sv
// rtl/adc_decimator_if.sv - averaged-word valid/ready readout handshake
interface adc_decimator_if #(
    parameter int RESOLUTION = 8
);
    logic                  avg_valid_o;
    logic                  avg_ready_i;
    logic [RESOLUTION-1:0] avg_data_o;

    // Decimator drives the word, readout stage drives ready
    modport master (output avg_valid_o, output avg_data_o, input avg_ready_i);
    modport slave  (input avg_valid_o, input avg_data_o, output avg_ready_i);
endinterface

// File: rtl/adc_decimator.sv
// rtl/adc_decimator.sv - ADC result capture, boxcar average and output FIFO
module adc_decimator #(
    parameter int RESOLUTION = 8,
    parameter int LOG2_AVG   = 2,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                             clk_i,
    input  logic                             rst_i,
    input  logic                             enable_i,
    input  logic                             adc_rdy_i,
    input  logic [RESOLUTION-1:0]            adc_result_i,
    adc_decimator_if.master                  avg_if,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]  fifo_level_o,
    output logic                             overflow_o,
    input  logic                             clear_ovf_i
);
    localparam int AW = RESOLUTION + LOG2_AVG;
    localparam int CW = (LOG2_AVG > 0) ? LOG2_AVG : 1;
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int LW = $clog2(FIFO_DEPTH + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'((1 << LOG2_AVG) - 1);
    localparam logic [LW-1:0] LVL_FULL = LW'(FIFO_DEPTH);

    logic                  r_rdy_prev;
    logic [AW-1:0]         r_sum;
    logic [CW-1:0]         r_cnt;
    logic [RESOLUTION-1:0] r_mem [FIFO_DEPTH];
    logic [PW-1:0]         r_wr_ptr;
    logic [PW-1:0]         r_rd_ptr;
    logic [LW-1:0]         r_level;
    logic                  r_ovf;

    logic                  w_cap;
    logic                  w_last;
    logic [AW-1:0]         w_sum_next;
    logic [RESOLUTION-1:0] w_avg;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_accept;
    logic                  w_valid;

    // Rising edge of the ready level; with LOG2_AVG=0 the counter never leaves 0
    assign w_cap      = adc_rdy_i & ~r_rdy_prev & enable_i;
    assign w_last     = (r_cnt == CNT_LAST);
    assign w_sum_next = r_sum + AW'(adc_result_i);
    assign w_avg      = w_sum_next[AW-1:LOG2_AVG];

    assign w_push   = w_cap & w_last;
    assign w_valid  = (r_level != '0);
    assign w_pop    = w_valid & avg_if.avg_ready_i;
    assign w_accept = w_push & ((r_level != LVL_FULL) | w_pop);

    // Outputs decode FIFO state only, so ready never reaches valid/data
    assign avg_if.avg_valid_o = w_valid;
    assign avg_if.avg_data_o  = w_valid ? r_mem[r_rd_ptr] : '0;
    assign fifo_level_o       = r_level;
    assign overflow_o         = r_ovf;

    // Edge detector and window accumulator; disabling drops the partial window
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_rdy_prev <= 1'b1;
            r_sum      <= '0;
            r_cnt      <= '0;
        end else begin
            r_rdy_prev <= adc_rdy_i;
            if (!enable_i) begin
                r_sum <= '0;
                r_cnt <= '0;
            end else if (w_cap) begin
                if (w_last) begin
                    r_sum <= '0;
                    r_cnt <= '0;
                end else begin
                    r_sum <= w_sum_next;
                    r_cnt <= r_cnt + CW'(1);
                end
            end
        end
    end

    // FIFO storage, written at the tail on every accepted push
    always_ff @(posedge clk_i) begin
        if (w_accept) begin
            r_mem[r_wr_ptr] <= w_avg;
        end
    end

    // FIFO pointers and level; push with pop leaves the level unchanged
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_accept) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            if (w_accept && !w_pop) begin
                r_level <= r_level + LW'(1);
            end else if (!w_accept && w_pop) begin
                r_level <= r_level - LW'(1);
            end
        end
    end

    // Sticky overflow; a new drop beats a simultaneous clear
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_ovf <= 1'b0;
        end else if (w_push && !w_accept) begin
            r_ovf <= 1'b1;
        end else if (clear_ovf_i) begin
            r_ovf <= 1'b0;
        end
    end
endmodule

// File: tb/tb_adc_decimator.sv
// tb/tb_adc_decimator.sv - directed self-checking bench for adc_decimator
module tb_adc_decimator;
    logic       clk;
    logic       rst;
    logic       en;
    logic       rdy;
    logic [7:0] res;
    logic       clr;
    logic [2:0] lvl;
    logic [2:0] lvl0;
    logic       ovf;
    logic       ovf0;

    int n_checks = 0;
    int n_fail   = 0;

    adc_decimator_if #(.RESOLUTION(8)) avg_if  ();
    adc_decimator_if #(.RESOLUTION(8)) avg_if0 ();

    adc_decimator #(.RESOLUTION(8), .LOG2_AVG(2), .FIFO_DEPTH(4)) u_dut (
        .clk_i(clk), .rst_i(rst), .enable_i(en), .adc_rdy_i(rdy),
        .adc_result_i(res), .avg_if(avg_if.master),
        .fifo_level_o(lvl), .overflow_o(ovf), .clear_ovf_i(clr)
    );

    adc_decimator #(.RESOLUTION(8), .LOG2_AVG(0), .FIFO_DEPTH(4)) u_dut0 (
        .clk_i(clk), .rst_i(rst), .enable_i(en), .adc_rdy_i(rdy),
        .adc_result_i(res), .avg_if(avg_if0.master),
        .fifo_level_o(lvl0), .overflow_o(ovf0), .clear_ovf_i(clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic rdy_edge(input logic [7:0] v);
        rdy = 1'b0;
        tick();
        rdy = 1'b1;
        res = v;
        tick();
    endtask

    task automatic window(input logic [7:0] v);
        repeat (4) rdy_edge(v);
    endtask

    initial begin
        rst = 1'b1; en = 1'b1; rdy = 1'b1; res = 8'd0; clr = 1'b0;
        avg_if.avg_ready_i  = 1'b0;
        avg_if0.avg_ready_i = 1'b0;
        tick(); tick();
        check("rst_valid", avg_if.avg_valid_o, 0);
        check("rst_data",  avg_if.avg_data_o, 0);
        check("rst_level", lvl, 0);
        check("rst_ovf",   ovf, 0);

        // Stale high ready after reset must not capture
        rst = 1'b0;
        tick(); tick();
        check("stale_valid", avg_if.avg_valid_o, 0);
        check("stale_level0", lvl0, 0);
        rdy_edge(8'd10);
        check("first_cap_valid", avg_if.avg_valid_o, 0);
        check("first_cap_level0", lvl0, 1);
        rdy_edge(8'd11);
        rdy_edge(8'd12);
        check("three_valid", avg_if.avg_valid_o, 0);
        rdy_edge(8'd14);
        check("avg47_valid", avg_if.avg_valid_o, 1);
        check("avg47_data",  avg_if.avg_data_o, 11);
        check("avg47_level", lvl, 1);

        // Fill with four 255 averages, then overflow on the fifth
        rst = 1'b1; tick(); rst = 1'b0;
        repeat (4) window(8'd255);
        check("full_level", lvl, 4);
        check("full_data",  avg_if.avg_data_o, 255);
        check("full_ovf",   ovf, 0);
        window(8'd255);
        check("ovf_set",   ovf, 1);
        check("ovf_level", lvl, 4);
        avg_if.avg_ready_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check("drain_valid", avg_if.avg_valid_o, 1);
            check("drain_data",  avg_if.avg_data_o, 255);
            tick();
        end
        avg_if.avg_ready_i = 1'b0;
        check("drained_valid", avg_if.avg_valid_o, 0);
        check("drained_level", lvl, 0);
        check("ovf_sticky", ovf, 1);
        clr = 1'b1; tick(); clr = 1'b0;
        check("ovf_clear", ovf, 0);

        // Full FIFO, fifth average lands in the same cycle as a pop
        window(8'd1); window(8'd2); window(8'd3); window(8'd4);
        check("full2_level", lvl, 4);
        check("full2_head",  avg_if.avg_data_o, 1);
        rdy_edge(8'd5); rdy_edge(8'd5); rdy_edge(8'd5);
        rdy = 1'b0; tick();
        rdy = 1'b1; res = 8'd5; avg_if.avg_ready_i = 1'b1;
        tick();
        check("pushpop_level", lvl, 4);
        check("pushpop_ovf",   ovf, 0);
        for (int i = 0; i < 4; i++) begin
            check("pushpop_order", avg_if.avg_data_o, i + 2);
            tick();
        end
        avg_if.avg_ready_i = 1'b0;
        check("pushpop_empty", avg_if.avg_valid_o, 0);

        // Disable discards a partial window
        rdy_edge(8'd100); rdy_edge(8'd100);
        en = 1'b0; tick(); en = 1'b1;
        window(8'd20);
        check("discard_valid", avg_if.avg_valid_o, 1);
        check("discard_data",  avg_if.avg_data_o, 20);
        check("discard_level", lvl, 1);
        avg_if.avg_ready_i = 1'b1; tick(); avg_if.avg_ready_i = 1'b0;
        check("discard_drain", avg_if.avg_valid_o, 0);

        // Pass-through build with ready held high
        rst = 1'b1; tick(); rst = 1'b0; tick();
        avg_if0.avg_ready_i = 1'b1;
        rdy = 1'b0; tick();
        check("pt_pre_valid", avg_if0.avg_valid_o, 0);
        rdy = 1'b1; res = 8'd0; tick();
        check("pt0_valid", avg_if0.avg_valid_o, 1);
        check("pt0_data",  avg_if0.avg_data_o, 0);
        rdy = 1'b0; tick();
        check("pt0_popped", avg_if0.avg_valid_o, 0);
        rdy = 1'b1; res = 8'd255; tick();
        check("pt255_valid", avg_if0.avg_valid_o, 1);
        check("pt255_data",  avg_if0.avg_data_o, 255);
        rdy = 1'b0; tick();
        check("pt255_popped", avg_if0.avg_valid_o, 0);
        rdy = 1'b1; res = 8'd128; tick();
        check("pt128_valid", avg_if0.avg_valid_o, 1);
        check("pt128_data",  avg_if0.avg_data_o, 128);
        tick();
        check("pt_end_level0", lvl0, 0);

        // Reset mid-window with both FIFOs holding data
        avg_if0.avg_ready_i = 1'b0;
        window(8'd8);
        rdy_edge(8'd8); rdy_edge(8'd8);
        check("pre_rst_valid", avg_if.avg_valid_o, 1);
        check("pre_rst_ovf0",  ovf0, 1);
        rst = 1'b1; tick(); rst = 1'b0;
        check("mid_rst_valid",  avg_if.avg_valid_o, 0);
        check("mid_rst_data",   avg_if.avg_data_o, 0);
        check("mid_rst_level",  lvl, 0);
        check("mid_rst_valid0", avg_if0.avg_valid_o, 0);
        check("mid_rst_data0",  avg_if0.avg_data_o, 0);
        check("mid_rst_level0", lvl0, 0);
        check("mid_rst_ovf0",   ovf0, 0);
        window(8'd40);
        check("post_rst_data", avg_if.avg_data_o, 40);
        check("post_rst_level", lvl, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
